acs_unit: RTL and testbench
===========================

Name: acs_unit

Overview:
Registered add-compare-select node for one trellis state of the hard-decision rate-1/2 Viterbi decoder. It sits directly downstream of the per-state branch-metric blocks and consumes their two 2-bit Hamming-distance metrics (range 0..2). It adds each metric to its predecessor's path metric, keeps the smaller sum, and applies global normalization. It also shifts the survivor decision into a local history register for the traceback unit.

Parameters:
PM_W, 8, path-metric width in bits (unsigned).
INIT_METRIC, 0, path metric loaded at reset/start (0 for state 0, 64 for all other states).
TB_LEN, 8, depth of the decision history register in bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  frame start; reloads initial state, synchronous
in_valid  input  1  one trellis step is presented this cycle
pm_a  input  PM_W  path metric of predecessor A (upper branch)
pm_b  input  PM_W  path metric of predecessor B (lower branch)
bm_a  input  2  branch metric for A->this state, 0..2
bm_b  input  2  branch metric for B->this state, 0..2
norm_in  input  1  global normalize request, sampled with in_valid
pm_out  output  PM_W  registered survivor path metric
pm_msb  output  1  pm_out[PM_W-1], for the external all-MSB normalize detector
dec_out  output  1  registered decision of the last step: 0 = A chosen, 1 = B chosen
out_valid  output  1  one-cycle pulse, pm_out/dec_out updated
dec_hist  output  TB_LEN  decision history; newest at bit 0
hist_full  output  1  at least TB_LEN steps accepted since reset/start

Behaviour:
- Reset (rst_n=0, async): pm_out=INIT_METRIC, pm_msb=INIT_METRIC[PM_W-1], dec_out=0, out_valid=0, dec_hist=0, hist_full=0, step counter=0.
- start=1 (sync): same values as reset. Takes priority over in_valid in the same cycle, and that beat is dropped (no out_valid).
- Step (in_valid=1, start=0):
  - sum_a=pm_a+bm_a and sum_b=pm_b+bm_b, computed at PM_W+1 bits.
  - Select: dec=(sum_b<sum_a). On a tie, dec=0 and A is kept.
  - sel=dec?sum_b:sum_a.
  - If norm_in=1: sel=sel-2^(PM_W-1), clamped to 0 if sel<2^(PM_W-1).
  - Saturate: if result >2^PM_W-1, then pm_out=2^PM_W-1.
  - Registered: pm_out, dec_out and pm_msb update on the clock edge, and out_valid=1 the next cycle. Latency is 1 cycle. Back-to-back in_valid every cycle is supported.
  - dec_hist <= {dec_hist[TB_LEN-2:0], dec}.
  - The step counter increments and saturates at TB_LEN. hist_full=1 from the edge that accepts the TB_LEN-th step.
- No step: pm_out, dec_out, dec_hist and hist_full hold. out_valid=0.
- Normalization is combinational on the selected sum only. pm_a/pm_b are used as given (the upstream array applies the same norm_in to all states).
- Reset asserted mid-frame returns all outputs to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset with INIT_METRIC=64, then release -> pm_out=64, pm_msb=0, dec_out=0, out_valid=0, dec_hist=0, hist_full=0.
- Basic select: pm_a=10, bm_a=2, pm_b=11, bm_b=0, in_valid 1 cycle -> next cycle pm_out=11, dec_out=1, out_valid=1 for exactly one cycle, dec_hist[0]=1.
- Tie and clamp:
  - pm_a=5/bm_a=1 vs pm_b=4/bm_b=2 -> pm_out=6, dec_out=0.
  - pm_a=254/bm_a=2 vs pm_b=255/bm_b=2 with norm_in=0 -> pm_out=255 (saturated), dec_out=0.
- Normalize:
  - pm_a=200/bm_a=1 vs pm_b=210/bm_b=0 with norm_in=1 -> pm_out=73, pm_msb=0, dec_out=0.
  - Selected sum 100 with norm_in=1 -> pm_out=0.
- History: 8 consecutive steps with decisions 1,0,1,1,0,0,1,0 (first to last) -> dec_hist=8'b10110010. hist_full rises on the same cycle as the 8th out_valid and stays high through a 9th step.
- start and in_valid together mid-frame -> pm_out=INIT_METRIC, no out_valid, dec_hist=0, hist_full=0. Then rst_n pulsed low between clock edges -> outputs return to reset values immediately.

Source files
------------

// File: rtl/acs_unit.sv
// acs_unit: registered add-compare-select node for one Viterbi trellis state.
// Adds branch metrics to predecessor path metrics, keeps the smaller sum,
// applies optional global normalization with clamp/saturate, and records the
// survivor decision in a local history shift register for traceback.
module acs_unit #(
  parameter int PM_W        = 8,
  parameter int INIT_METRIC = 0,
  parameter int TB_LEN      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PM_W-1:0]   pm_a,
  input  logic [PM_W-1:0]   pm_b,
  input  logic [1:0]        bm_a,
  input  logic [1:0]        bm_b,
  input  logic              norm_in,
  output logic [PM_W-1:0]   pm_out,
  output logic              pm_msb,
  output logic              dec_out,
  output logic              out_valid,
  output logic [TB_LEN-1:0] dec_hist,
  output logic              hist_full
);

  localparam int              CNT_W   = $clog2(TB_LEN + 1);
  localparam logic [PM_W-1:0] INIT_PM = PM_W'(INIT_METRIC);
  localparam logic [PM_W:0]   HALF    = (PM_W+1)'(1) << (PM_W - 1);
  localparam logic [PM_W:0]   PM_MAX  = {1'b0, {PM_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_LEN);

  // Subtract half range when normalizing (floor at zero), then clip to PM_W bits.
  function automatic logic [PM_W-1:0] norm_sat(input logic [PM_W:0] sel,
                                                input logic          norm);
    logic [PM_W:0] r;
    r = sel;
    if (norm) begin
      r = (sel < HALF) ? '0 : (sel - HALF);
    end
    if (r > PM_MAX) begin
      r = PM_MAX;
    end
    return r[PM_W-1:0];
  endfunction

  logic [PM_W:0]      sum_a;
  logic [PM_W:0]      sum_b;
  logic               dec;
  logic [PM_W-1:0]    pm_next;

  logic [PM_W-1:0]    pm_p0;
  logic               dec_p0;
  logic               vld_p0;
  logic [TB_LEN-1:0]  hist_p0;
  logic               full_p0;
  logic [CNT_W-1:0]   cnt_p0;

  // Add, compare (ties keep A) and select, then normalize/saturate.
  always_comb begin
    sum_a   = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
    sum_b   = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
    dec     = (sum_b < sum_a);
    pm_next = norm_sat(dec ? sum_b : sum_a, norm_in);
  end

  // ---- stage p0: survivor metric, decision, history and step count ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_p0   <= INIT_PM;
      dec_p0  <= 1'b0;
      vld_p0  <= 1'b0;
      hist_p0 <= '0;
      full_p0 <= 1'b0;
      cnt_p0  <= '0;
    end else if (start) begin
      pm_p0   <= INIT_PM;
      dec_p0  <= 1'b0;
      vld_p0  <= 1'b0;
      hist_p0 <= '0;
      full_p0 <= 1'b0;
      cnt_p0  <= '0;
    end else if (in_valid) begin
      pm_p0   <= pm_next;
      dec_p0  <= dec;
      vld_p0  <= 1'b1;
      hist_p0 <= {hist_p0[TB_LEN-2:0], dec};
      if (cnt_p0 != CNT_FULL) begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
      if (cnt_p0 >= CNT_FULL - CNT_W'(1)) begin
        full_p0 <= 1'b1;
      end
    end else begin
      vld_p0  <= 1'b0;
    end
  end

  assign pm_out    = pm_p0;
  assign pm_msb    = pm_p0[PM_W-1];
  assign dec_out   = dec_p0;
  assign out_valid = vld_p0;
  assign dec_hist  = hist_p0;
  assign hist_full = full_p0;

endmodule

// File: tb/tb_acs_unit.sv
// tb_acs_unit: directed bench for acs_unit (PM_W=8, INIT_METRIC=64, TB_LEN=8).
module tb_acs_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] pm_a;
  logic [7:0] pm_b;
  logic [1:0] bm_a;
  logic [1:0] bm_b;
  logic       norm_in;
  logic [7:0] pm_out;
  logic       pm_msb;
  logic       dec_out;
  logic       out_valid;
  logic [7:0] dec_hist;
  logic       hist_full;

  int n_cmp;
  int n_err;

  acs_unit #(.PM_W(8), .INIT_METRIC(64), .TB_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .pm_a(pm_a), .pm_b(pm_b), .bm_a(bm_a), .bm_b(bm_b), .norm_in(norm_in),
    .pm_out(pm_out), .pm_msb(pm_msb), .dec_out(dec_out), .out_valid(out_valid),
    .dec_hist(dec_hist), .hist_full(hist_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one step at the falling edge, then sample just after the rising edge.
  task automatic step(input logic [7:0] pa, input logic [1:0] ba,
                      input logic [7:0] pb, input logic [1:0] bb, input logic nrm);
    @(negedge clk);
    pm_a = pa; bm_a = ba; pm_b = pb; bm_b = bb; norm_in = nrm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    norm_in  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Steps that force a known decision: dec=1 gives 11, dec=0 is a tie giving 6.
  task automatic step_dec(input logic d);
    if (d) step(8'd10, 2'd2, 8'd11, 2'd0, 1'b0);
    else   step(8'd5,  2'd1, 8'd4,  2'd2, 1'b0);
  endtask

  initial begin
    logic [7:0] pattern;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; norm_in = 1'b0;
    pm_a = '0; pm_b = '0; bm_a = '0; bm_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pm", pm_out, 64);
    chk("rst_msb", pm_msb, 0);
    chk("rst_dec", dec_out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_hist", dec_hist, 0);
    chk("rst_full", hist_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_pm", pm_out, 64);
    chk("rel_vld", out_valid, 0);

    // Basic select: 12 vs 11 -> B
    step(8'd10, 2'd2, 8'd11, 2'd0, 1'b0);
    chk("basic_pm", pm_out, 11);
    chk("basic_dec", dec_out, 1);
    chk("basic_vld", out_valid, 1);
    chk("basic_hist0", dec_hist[0], 1);
    idle();
    chk("basic_vld_drop", out_valid, 0);
    chk("basic_pm_hold", pm_out, 11);

    // Tie 6 vs 6 -> A
    step(8'd5, 2'd1, 8'd4, 2'd2, 1'b0);
    chk("tie_pm", pm_out, 6);
    chk("tie_dec", dec_out, 0);

    // 256 vs 257 -> A, saturated to 255
    step(8'd254, 2'd2, 8'd255, 2'd2, 1'b0);
    chk("sat_pm", pm_out, 255);
    chk("sat_dec", dec_out, 0);
    chk("sat_msb", pm_msb, 1);

    // 201 vs 210 -> A, normalized 201-128=73
    step(8'd200, 2'd1, 8'd210, 2'd0, 1'b1);
    chk("norm_pm", pm_out, 73);
    chk("norm_msb", pm_msb, 0);
    chk("norm_dec", dec_out, 0);

    // Selected 100 with normalize -> clamp to 0
    step(8'd100, 2'd0, 8'd120, 2'd0, 1'b1);
    chk("clamp_pm", pm_out, 0);
    chk("clamp_full", hist_full, 0);

    // Restart, then eight back-to-back steps 1,0,1,1,0,0,1,0
    @(negedge clk);
    in_valid = 1'b0; norm_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_pm", pm_out, 64);
    chk("start_hist", dec_hist, 0);
    @(negedge clk);
    start = 1'b0;
    pattern = 8'b10110010;
    for (int i = 7; i >= 0; i--) begin
      step_dec(pattern[i]);
      chk("hist_vld", out_valid, 1);
      if (i > 0) chk("hist_full_early", hist_full, 0);
    end
    chk("hist_val", dec_hist, 8'b10110010);
    chk("hist_full8", hist_full, 1);
    step_dec(1'b1);
    chk("hist_val9", dec_hist, 8'b01100101);
    chk("hist_full9", hist_full, 1);
    chk("pm9", pm_out, 11);

    // start together with in_valid: beat dropped
    @(negedge clk);
    pm_a = 8'd10; bm_a = 2'd2; pm_b = 8'd11; bm_b = 2'd0;
    in_valid = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    chk("sv_pm", pm_out, 64);
    chk("sv_vld", out_valid, 0);
    chk("sv_hist", dec_hist, 0);
    chk("sv_full", hist_full, 0);
    chk("sv_dec", dec_out, 0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;

    // One step, then async reset between clock edges
    step_dec(1'b1);
    chk("pre_rst_pm", pm_out, 11);
    chk("pre_rst_vld", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pm", pm_out, 64);
    chk("arst_vld", out_valid, 0);
    chk("arst_dec", dec_out, 0);
    chk("arst_hist", dec_hist, 0);
    chk("arst_full", hist_full, 0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
